// File: rtl/bsg_manycore_pkg.sv
// Shared manycore definitions: remote packet op codes and packet sizing.
// Packet layout (MSB..LSB): addr, op, mask, data, src_y, src_x, dst_y, dst_x.
package bsg_manycore_pkg;

  localparam logic [1:0] OP_STORE_LO_C = 2'b01;
  localparam logic [1:0] OP_STORE_HI_C = 2'b10;

  // addr loses the remote flag, coordinates and top local bit, but the
  // packet adds op (2) plus source and destination coordinates.
  function automatic int pkt_width(int aw, int dw, int xw, int yw);
    return aw + dw + (dw / 8) + xw + yw;
  endfunction

endpackage

// File: rtl/bsg_manycore_pkt_encode.sv
// Encodes one requester's access into a manycore remote packet.
// Ports: v/addr/data/mask/we request, my_x/my_y source, st_v/ld_v/packet out.
module bsg_manycore_pkt_encode
  import bsg_manycore_pkg::*;
#(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 20,
  localparam int packet_width_lp = pkt_width(addr_width_p, data_width_p,
                                             x_cord_width_p, y_cord_width_p)
) (
  input  logic                       v_i,
  input  logic [addr_width_p-1:0]    addr_i,
  input  logic [data_width_p-1:0]    data_i,
  input  logic [(data_width_p>>3)-1:0] mask_i,
  input  logic                       we_i,
  input  logic [x_cord_width_p-1:0]  my_x_i,
  input  logic [y_cord_width_p-1:0]  my_y_i,
  output logic                       st_v_o,
  output logic                       ld_v_o,
  output logic [packet_width_lp-1:0] packet_o
);

  localparam int la_lp = addr_width_p - 1 - x_cord_width_p - y_cord_width_p;

  logic                      w_remote;
  logic [y_cord_width_p-1:0] w_dst_y;
  logic [x_cord_width_p-1:0] w_dst_x;
  logic [la_lp-1:0]          w_local;
  logic [1:0]                w_op;

  // addr = {remote, y, x, local}
  assign {w_remote, w_dst_y, w_dst_x, w_local} = addr_i;

  assign w_op = w_local[la_lp-1] ? OP_STORE_HI_C : OP_STORE_LO_C;

  assign st_v_o = v_i & we_i & w_remote;
  assign ld_v_o = v_i & ~we_i & w_remote;

  assign packet_o = {w_local[la_lp-2:0], w_op, mask_i, data_i,
                     my_y_i, my_x_i, w_dst_y, w_dst_x};

endmodule

// File: rtl/bsg_manycore_remote_store_arb.sv
// Round-robin, credit-gated arbiter of two remote-store masters onto one link.
// Ports: 2x request in, yumi_o, v_o/packet_o/ready_i link, credit in/out, errors.
module bsg_manycore_remote_store_arb
  import bsg_manycore_pkg::*;
#(
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 20,
  parameter int max_out_credits_p = 16,
  localparam int packet_width_lp = pkt_width(addr_width_p, data_width_p,
                                             x_cord_width_p, y_cord_width_p),
  localparam int credit_width_lp = $clog2(max_out_credits_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [1:0]                        v_i,
  input  logic [1:0][addr_width_p-1:0]      addr_i,
  input  logic [1:0][data_width_p-1:0]      data_i,
  input  logic [1:0][(data_width_p>>3)-1:0] mask_i,
  input  logic [1:0]                        we_i,
  output logic [1:0]                        yumi_o,
  input  logic [x_cord_width_p-1:0]         my_x_i,
  input  logic [y_cord_width_p-1:0]         my_y_i,
  output logic                              v_o,
  output logic [packet_width_lp-1:0]        packet_o,
  input  logic                              ready_i,
  input  logic                              credit_v_i,
  output logic [credit_width_lp-1:0]        out_credits_o,
  output logic                              remote_load_err_o,
  output logic                              credit_err_o
);

  localparam logic [credit_width_lp-1:0] max_c =
    credit_width_lp'(max_out_credits_p);

  logic [1:0]                       w_st_v;
  logic [1:0]                       w_ld_v;
  logic [1:0]                       w_grant;
  logic [1:0][packet_width_lp-1:0]  w_pkt;
  logic                             w_slot_free;
  logic                             w_can_send;
  logic                             w_gv;

  logic                       r_v;
  logic [packet_width_lp-1:0] r_pkt;
  logic [credit_width_lp-1:0] r_cred;
  logic                       r_last;
  logic                       r_ld_err;
  logic                       r_cr_err;

  for (genvar i = 0; i < 2; i++) begin : g_enc
    bsg_manycore_pkt_encode #(
      .x_cord_width_p(x_cord_width_p),
      .y_cord_width_p(y_cord_width_p),
      .data_width_p  (data_width_p),
      .addr_width_p  (addr_width_p)
    ) u_enc (
      .v_i     (v_i[i]),
      .addr_i  (addr_i[i]),
      .data_i  (data_i[i]),
      .mask_i  (mask_i[i]),
      .we_i    (we_i[i]),
      .my_x_i  (my_x_i),
      .my_y_i  (my_y_i),
      .st_v_o  (w_st_v[i]),
      .ld_v_o  (w_ld_v[i]),
      .packet_o(w_pkt[i])
    );
  end

  assign w_slot_free = ~r_v | ready_i;
  assign w_can_send  = w_slot_free & (r_cred != '0);

  always_comb begin
    w_grant = 2'b00;
    if (w_can_send) begin
      if (&w_st_v) w_grant = r_last ? 2'b01 : 2'b10;
      else         w_grant = w_st_v;
    end
  end

  assign w_gv   = |w_grant;
  assign yumi_o = w_grant | w_ld_v;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v      <= 1'b0;
      r_pkt    <= '0;
      r_cred   <= max_c;
      r_last   <= 1'b1;
      r_ld_err <= 1'b0;
      r_cr_err <= 1'b0;
    end else begin
      r_ld_err <= |w_ld_v;
      if (w_gv) begin
        r_v    <= 1'b1;
        r_pkt  <= w_grant[1] ? w_pkt[1] : w_pkt[0];
        r_last <= w_grant[1];
      end else if (r_v & ready_i) begin
        r_v <= 1'b0;
      end
      if (w_gv & ~credit_v_i) begin
        r_cred <= r_cred - 1'b1;
      end else if (credit_v_i & ~w_gv) begin
        if (r_cred == max_c) r_cr_err <= 1'b1;
        else                 r_cred   <= r_cred + 1'b1;
      end
    end
  end

  assign v_o               = r_v;
  assign packet_o          = r_pkt;
  assign out_credits_o     = r_cred;
  assign remote_load_err_o = r_ld_err;
  assign credit_err_o      = r_cr_err;

endmodule
